// File: rtl/vcpu_defs_pkg.sv
// Shared definitions for the vcpu1 pipeline: datapath width, register-index
// width, ALU opcode encodings and the execute-stage divider FSM states.
package vcpu_defs;

    localparam int XLEN       = 32;
    localparam int REG_W      = 5;
    localparam int DIV_CYCLES = 32;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLL  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_SLT  = 5'd9,
        ALU_SLTU = 5'd10,
        ALU_LUI  = 5'd11,
        ALU_DIV  = 5'd12,
        ALU_DIVU = 5'd13,
        ALU_REM  = 5'd14,
        ALU_REMU = 5'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_stage_divider.sv
// ex_divider: unsigned restoring divider, one quotient bit per cycle.
// A start pulse loads the operands; done pulses for one cycle once the last
// bit is produced, and quotient/remainder hold until the next start.
module ex_divider
    import vcpu_defs::*;
#(
    parameter int W      = vcpu_defs::XLEN,
    parameter int CYCLES = vcpu_defs::DIV_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [W-1:0]  dvsr;
    logic [CW-1:0] cnt;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          fits;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        shifted = {remainder, quotient[W-1]};
        diff    = shifted - {1'b0, dvsr};
        fits    = (shifted >= {1'b0, dvsr});
    end

    // Iteration registers; the quotient register doubles as the dividend shifter.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            dvsr      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            dvsr      <= divisor;
            quotient  <= dividend;
            remainder <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else if (busy) begin
            remainder <= fits ? diff[W-1:0] : shifted[W-1:0];
            quotient  <= {quotient[W-2:0], fits};
            cnt       <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the vcpu1 pipeline. Single-cycle ALU ops are
// registered with latency 1. With EX_STAGE_DIV_EN defined, DIV/DIVU/REM/REMU
// run on an iterative divider and stall upstream; without it those opcodes
// behave as undefined ops.
module ex_stage
    import vcpu_defs::*;
#(
    parameter int XLEN       = vcpu_defs::XLEN,
    parameter int DIV_CYCLES = vcpu_defs::DIV_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [4:0]      aluop,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      in_wd,
    input  logic            in_wreg,
    input  logic            flush,
    output logic            stall_req,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_wd,
    output logic            out_wreg
);

    if (DIV_CYCLES != XLEN) begin : g_bad_cfg
        $error("ex_stage: DIV_CYCLES must equal XLEN");
    end

    logic [XLEN-1:0] alu_res;
    logic            alu_def;
    logic            accept_alu;
    logic            div_fast;
    logic [XLEN-1:0] div_fast_res;
    logic            div_finish;
    logic [XLEN-1:0] div_final_res;
    logic [4:0]      div_wd;
    logic            div_wreg;
    logic            nxt_valid;
    logic [XLEN-1:0] nxt_result;
    logic [4:0]      nxt_wd;
    logic            nxt_wreg;

    // Single-cycle ALU; anything not listed is an undefined opcode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        alu_res = '0;
        alu_def = 1'b1;
        case (aluop)
            ALU_ADD:  alu_res = op1 + op2;
            ALU_SUB:  alu_res = op1 - op2;
            ALU_AND:  alu_res = op1 & op2;
            ALU_OR:   alu_res = op1 | op2;
            ALU_XOR:  alu_res = op1 ^ op2;
            ALU_NOR:  alu_res = ~(op1 | op2);
            ALU_SLL:  alu_res = op1 << op2[4:0];
            ALU_SRL:  alu_res = op1 >> op2[4:0];
            ALU_SRA:  alu_res = $unsigned($signed(op1) >>> op2[4:0]);
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_LUI:  alu_res = {op2[15:0], 16'h0000};
            default:  alu_def = 1'b0;
        endcase
    end

`ifdef EX_STAGE_DIV_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state, state_nxt;
    logic            is_div_op, op_signed, op_rem;
    logic            div_by_zero, div_ovf, div_start;
    logic [XLEN-1:0] abs1, abs2;
    logic            q_neg, r_neg, sel_rem;
    logic            dv_busy, dv_done;
    logic [XLEN-1:0] dv_quo, dv_rem;

    // Decode divide ops, detect the single-cycle special cases, form magnitudes.
    always_comb begin
        is_div_op   = (aluop == ALU_DIV) || (aluop == ALU_DIVU) ||
                      (aluop == ALU_REM) || (aluop == ALU_REMU);
        op_signed   = (aluop == ALU_DIV) || (aluop == ALU_REM);
        op_rem      = (aluop == ALU_REM) || (aluop == ALU_REMU);
        div_by_zero = (op2 == '0);
        div_ovf     = op_signed && (op1 == INT_MIN) && (op2 == '1);
        abs1        = (op_signed && op1[XLEN-1]) ? -op1 : op1;
        abs2        = (op_signed && op2[XLEN-1]) ? -op2 : op2;
        if (div_by_zero)
            div_fast_res = op_rem ? op1 : '1;
        else
            div_fast_res = op_rem ? '0 : INT_MIN;
    end

    // Divider FSM next state and stall; flush overrides everything.
    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        stall_req = 1'b0;
        case (state)
            IDLE: if (in_valid && is_div_op && !div_by_zero && !div_ovf) begin
                div_start = 1'b1;
                stall_req = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                stall_req = 1'b1;
                if (dv_done) state_nxt = DONE;
            end
            DONE: begin
                stall_req = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            div_start = 1'b0;
            stall_req = 1'b0;
        end
        if (rst) stall_req = 1'b0;
    end

    // FSM state and the per-division context captured at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            sel_rem  <= 1'b0;
            div_wd   <= '0;
            div_wreg <= 1'b0;
        end else begin
            state <= state_nxt;
            if (div_start) begin
                q_neg    <= op_signed && (op1[XLEN-1] ^ op2[XLEN-1]);
                r_neg    <= op_signed && op1[XLEN-1];
                sel_rem  <= op_rem;
                div_wd   <= in_wd;
                div_wreg <= in_wreg;
            end
        end
    end

    ex_divider #(.W(XLEN), .CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .dividend  (abs1),
        .divisor   (abs2),
        .busy      (dv_busy),
        .done      (dv_done),
        .quotient  (dv_quo),
        .remainder (dv_rem)
    );

    // Hand-off signals to the output register, with sign correction in DONE.
    always_comb begin
        accept_alu    = in_valid && (state == IDLE) && !is_div_op;
        div_fast      = in_valid && (state == IDLE) && is_div_op && (div_by_zero || div_ovf);
        div_finish    = (state == DONE) && !dv_busy;
        div_final_res = sel_rem ? (r_neg ? -dv_rem : dv_rem)
                                : (q_neg ? -dv_quo : dv_quo);
    end
`else
    assign stall_req     = 1'b0;
    assign accept_alu    = in_valid;
    assign div_fast      = 1'b0;
    assign div_fast_res  = '0;
    assign div_finish    = 1'b0;
    assign div_final_res = '0;
    assign div_wd        = '0;
    assign div_wreg      = 1'b0;
`endif

    // Next output values; flush discards whatever completes this cycle.
    always_comb begin
        nxt_valid  = 1'b0;
        nxt_result = out_result;
        nxt_wd     = out_wd;
        nxt_wreg   = 1'b0;
        if (!flush) begin
            if (accept_alu) begin
                nxt_valid  = 1'b1;
                nxt_result = alu_def ? alu_res : '0;
                nxt_wd     = in_wd;
                nxt_wreg   = in_wreg && alu_def;
            end else if (div_fast) begin
                nxt_valid  = 1'b1;
                nxt_result = div_fast_res;
                nxt_wd     = in_wd;
                nxt_wreg   = in_wreg;
            end else if (div_finish) begin
                nxt_valid  = 1'b1;
                nxt_result = div_final_res;
                nxt_wd     = div_wd;
                nxt_wreg   = div_wreg;
            end
        end
    end

    // Registered result for MEM/WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_wd     <= '0;
            out_wreg   <= 1'b0;
        end else begin
            out_valid  <= nxt_valid;
            out_result <= nxt_result;
            out_wd     <= nxt_wd;
            out_wreg   <= nxt_wreg;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected results (value,
// destination, write enable, arrival cycle); a negedge monitor pops and
// compares whenever out_valid is high. Expectations follow EX_STAGE_DIV_EN.
`timescale 1ns/1ps
module tb_ex_stage;
    import vcpu_defs::*;

`ifdef EX_STAGE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  aluop;
    logic [31:0] op1, op2;
    logic [4:0]  in_wd;
    logic        in_wreg;
    logic        flush;
    logic        stall_req;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_wd;
    logic        out_wreg;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .aluop      (aluop),
        .op1        (op1),
        .op2        (op2),
        .in_wd      (in_wd),
        .in_wreg    (in_wreg),
        .flush      (flush),
        .stall_req  (stall_req),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_wd     (out_wd),
        .out_wreg   (out_wreg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wd;
        logic        wreg;
        int          at;
    } exp_t;
    exp_t sb[$];

    int stall_hits = 0;
    always @(negedge clk) if (stall_req) stall_hits++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every presented result against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", out_result, e.res);
                    check("wd", 32'(out_wd), 32'(e.wd));
                    check("wreg", 32'(out_wreg), 32'(e.wreg));
                    check("arrival_cycle", cyc, e.at);
                end
            end else begin
                check("wreg_when_idle", 32'(out_wreg), 32'd0);
            end
        end
    end

    // Present one op for one cycle; k = extra edges after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wreg,
                         input logic [31:0] eres, input logic ewreg, input int k);
        in_valid = 1'b1; aluop = op; op1 = a; op2 = b; in_wd = wd; in_wreg = wreg;
        sb.push_back('{eres, wd, ewreg, cyc + 1 + k});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Iterative divide: check accept-cycle stall and total stall length.
    task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wd, input logic [31:0] eres, input string name);
        int n;
        in_valid = 1'b1; aluop = op; op1 = a; op2 = b; in_wd = wd; in_wreg = 1'b1;
        sb.push_back('{(DIV_EN ? eres : 32'h0), wd, DIV_EN, cyc + 1 + (DIV_EN ? 34 : 0)});
        #1;
        check({name, "_stall_accept"}, 32'(stall_req), 32'(DIV_EN));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && stall_req; i++) begin
            n++;
            @(posedge clk); #1;
        end
        check({name, "_stall_cycles"}, n, DIV_EN ? 34 : 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int s0;
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b1; aluop = ALU_ADD; op1 = 32'd5; op2 = 32'd7; in_wd = 5'd3; in_wreg = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_wd", 32'(out_wd), 32'd0);
        check("rst_out_wreg", 32'(out_wreg), 32'd0);
        aluop = ALU_DIV; op2 = 32'd2;
        #1;
        check("rst_stall_req", 32'(stall_req), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 32'd12, 1'b1, 0);

        s0 = stall_hits;
        issue(ALU_SUB,  32'd0,         32'd1,         5'd1, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
        issue(ALU_SRA,  32'h8000_0000, 32'd4,         5'd2, 1'b1, 32'hF800_0000, 1'b1, 0);
        issue(ALU_SLTU, 32'd1,         32'hFFFF_FFFF, 5'd4, 1'b1, 32'd1,         1'b1, 0);
        issue(ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd5, 1'b1, 32'h00F0_1200, 1'b1, 0);
        issue(ALU_OR,   32'hF000_000F, 32'h0000_F0F0, 5'd6, 1'b0, 32'hF000_F0FF, 1'b0, 0);
        issue(ALU_XOR,  32'hFFFF_0000, 32'hFF00_FF00, 5'd7, 1'b1, 32'h00FF_FF00, 1'b1, 0);
        issue(ALU_NOR,  32'h0000_00FF, 32'hFF00_0000, 5'd8, 1'b1, 32'h00FF_FF00, 1'b1, 0);
        issue(ALU_SLL,  32'd1,         32'h0000_0021, 5'd9, 1'b1, 32'd2,         1'b1, 0);
        issue(ALU_SRL,  32'h8000_0000, 32'd4,         5'd10, 1'b1, 32'h0800_0000, 1'b1, 0);
        issue(ALU_SLT,  32'hFFFF_FFFF, 32'd1,         5'd11, 1'b1, 32'd1,         1'b1, 0);
        issue(ALU_SLT,  32'd1,         32'hFFFF_FFFF, 5'd12, 1'b1, 32'd0,         1'b1, 0);
        issue(ALU_LUI,  32'h0,         32'h1234_ABCD, 5'd13, 1'b1, 32'hABCD_0000, 1'b1, 0);
        issue(ALU_ADD,  32'hFFFF_FFFF, 32'd2,         5'd14, 1'b1, 32'd1,         1'b1, 0);
        issue(5'd31,    32'd9,         32'd9,         5'd15, 1'b1, 32'd0,         1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("alu_no_stall", stall_hits - s0, 0);

        run_div(ALU_DIV,  32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFD, "div_m7_2");
        run_div(ALU_REM,  32'hFFFF_FFF9, 32'd2, 5'd17, 32'hFFFF_FFFF, "rem_m7_2");
        run_div(ALU_DIVU, 32'd100,       32'd7, 5'd18, 32'd14,        "divu_100_7");

        s0 = stall_hits;
        issue(ALU_DIV,  32'd5,         32'd0,         5'd19, 1'b1, DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN, 0);
        issue(ALU_REMU, 32'd5,         32'd0,         5'd20, 1'b1, DIV_EN ? 32'd5 : 32'h0,         DIV_EN, 0);
        issue(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 1'b1, DIV_EN ? 32'h8000_0000 : 32'h0, DIV_EN, 0);
        issue(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 1'b1, 32'h0,                          DIV_EN, 0);
        repeat (2) @(posedge clk);
        #1;
        check("special_no_stall", stall_hits - s0, 0);

        // Flush during the divide: no result from it, FSM back in IDLE.
        in_valid = 1'b1; aluop = ALU_DIVU; op1 = 32'd100; op2 = 32'd7; in_wd = 5'd23; in_wreg = 1'b1;
        if (!DIV_EN) sb.push_back('{32'h0, 5'd23, 1'b0, cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1; aluop = ALU_ADD; op1 = 32'd1; op2 = 32'd1; in_wd = 5'd24;
        #1;
        check("flush_stall_low", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("post_flush_idle", 32'(stall_req), 32'd0);
        issue(ALU_ADD, 32'd40, 32'd2, 5'd25, 1'b1, 32'd42, 1'b1, 0);
        repeat (40) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the vcpu1 pipeline. Directly downstream of operand generation.
- Consumes the resolved 32-bit operands op1/op2 together with the decoded ALU opcode and write-back control.
- Produces a registered result for the MEM/WB path.
- Single-cycle ALU ops complete in one cycle. Iterative divide/remainder stalls upstream until its result is ready.

Parameters:
- XLEN, 32, datapath width
- DIV_CYCLES, 32, divider iterations (one quotient bit per cycle; must equal XLEN)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/opcode valid this cycle
- aluop  in  5  operation code (see package)
- op1  in  XLEN  first operand
- op2  in  XLEN  second operand
- in_wd  in  5  destination register index
- in_wreg  in  1  destination write enable
- flush  in  1  kill in-flight operation (branch/exception)
- stall_req  out  1  upstream must hold its inputs stable
- out_valid  out  1  result valid
- out_result  out  XLEN  result
- out_wd  out  5  destination index, aligned with out_result
- out_wreg  out  1  write enable, aligned; forced 0 when out_valid=0

Behaviour:
- Reset (async, rst=1): out_valid=0, out_result=0, out_wd=0, out_wreg=0, FSM=IDLE, divider counter=0. stall_req=0 during reset.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, NOR, SLL, SRL, SRA, SLT, SLTU, LUI.
  - Accepted when in_valid=1 and FSM=IDLE.
  - out_* registered at the next edge (latency 1).
  - out_valid is high for exactly one cycle per accepted op.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^32; no overflow trap.
  - Shift amount = op2[4:0].
  - SLT is signed; SLTU is unsigned. Both return 0 or 1.
  - LUI returns {op2[15:0],16'h0}.
- Undefined aluop: result 0, out_wreg forced 0, out_valid still 1.
- FSM for DIV, DIVU, REM, REMU; states IDLE -> BUSY -> DONE -> IDLE.
  - IDLE, in_valid=1 with a div op: latch |op1|, |op2| and the sign flags; counter=0; go to BUSY. stall_req=1 combinationally in this accept cycle.
  - BUSY: restoring division, one quotient bit per cycle. Counter increments. After DIV_CYCLES iterations go to DONE. stall_req=1.
  - DONE: apply sign correction, register out_*, then go to IDLE. stall_req=1 in DONE; it drops the cycle out_valid rises.
  - Total: out_valid asserts DIV_CYCLES+2 = 34 edges after the accept edge.
- Divide by zero: handled in IDLE, no BUSY, latency 1 like an ALU op.
  - DIV/DIVU quotient = 32'hFFFF_FFFF.
  - REM/REMU result = op1.
- Signed overflow (DIV/REM, 32'h8000_0000 / 32'hFFFF_FFFF): quotient 32'h8000_0000, remainder 0, latency 1.
- Signs: quotient sign = op1[31]^op2[31]; remainder takes the sign of op1.
- flush:
  - Highest priority, ahead of new acceptance.
  - On the edge with flush=1: FSM->IDLE, out_valid=0, out_wreg=0, and any op presented that cycle is discarded.
  - stall_req goes 0 combinationally while flush=1.
- in_valid=0 in IDLE: out_valid=0 next cycle. out_result holds its last value (don't-care).
- Inputs presented while BUSY/DONE are ignored. Upstream guarantees they are held stable because stall_req=1.

Optional Feature:
- Macro: EX_STAGE_DIV_EN.
- Defined: divider FSM and sub-module as above.
- Undefined:
  - No divider logic; FSM absent; stall_req tied 0.
  - DIV/DIVU/REM/REMU are treated as undefined aluop: result 0, out_wreg=0, latency 1.

Decomposition:
- Shared package vcpu_defs:
  - aluop encodings (ALU_ADD=5'd0 … ALU_REMU), XLEN, register-index width.
  - FSM state typedef {IDLE, BUSY, DONE}.
- Sub-module ex_divider:
  - Unsigned restoring core: start, dividend, divisor -> busy, done, quotient, remainder.
  - Sign handling, special cases and the output register stay in ex_stage.

Test Plan:
- Reset with inputs active -> all outputs 0 while rst=1; after release, ADD 5+7 (in_wd=3, in_wreg=1) -> next cycle out_valid=1, out_result=12, out_wd=3, out_wreg=1.
- Back-to-back single-cycle ops SUB 0-1, then SRA 32'h8000_0000>>4, then SLTU 1<FFFFFFFF -> consecutive cycles FFFFFFFF, F8000000, 1; stall_req never asserted.
- DIV -7/2 -> stall_req high 34 cycles, out_valid on edge 34 with 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14.
- DIV 5/0 -> latency 1, FFFFFFFF; REMU 5/0 -> 5; DIV 80000000/FFFFFFFF -> 80000000; no stall.
- Flush at cycle 10 of BUSY -> stall_req 0 that cycle, no out_valid, FSM IDLE; an ADD issued next cycle completes with latency 1.
- Build without EX_STAGE_DIV_EN: DIVU 100/7 -> latency 1, out_result=0, out_wreg=0, stall_req stuck 0.
